// File: rtl/k_and_s_data_path_p.sv
// k_and_s_data_path_p: K&S data path (IR, PC, R0..R3, flags, ALU, optional iterative multiplier enabled by KS_DP_MUL_EN)
package k_and_s_pkg;
  typedef enum logic [4:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_MUL,
    I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO, I_HALT
  } decoded_instruction_type;
endpackage

module k_and_s_data_path_p
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic                    rst_n,
  input  logic                    clk,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic                    write_reg_enable,
  input  logic                    flags_reg_enable,
  input  logic [1:0]              operation,
  input  logic                    mul_start,
  output logic                    mul_busy,
  output logic                    mul_done,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       data_out,
  input  logic [DATA_W-1:0]       data_in
);
  localparam int M = DATA_W - 1;
  logic [15:0]        ir;
  logic [ADDR_W-1:0]  pc, mem_addr;
  logic [DATA_W-1:0]  r [4];
  logic [1:0]         ra, rb, rc;
  logic               alu_fmt, is_br, is_mem;
  logic [DATA_W-1:0]  a_op, b_op, alu_out;
  logic [DATA_W:0]    sum, diff;
  logic               alu_uov, alu_sov;
  logic               wb;
  logic [1:0]         mc;
  logic [2*DATA_W-1:0] prod;
  logic               unused_ir7;
  assign unused_ir7 = ir[7];
  // opcode decode; anything unrecognised is a NOP
  always_comb begin
    decoded_instruction = I_NOP;
    case (ir[15:8])
      8'h81: decoded_instruction = I_LOAD;
      8'h82: decoded_instruction = I_STORE;
      8'h91: decoded_instruction = I_MOVE;
      8'hA1: decoded_instruction = I_ADD;
      8'hA2: decoded_instruction = I_SUB;
      8'hA3: decoded_instruction = I_AND;
      8'hA4: decoded_instruction = I_OR;
`ifdef KS_DP_MUL_EN
      8'hA5: decoded_instruction = I_MUL;
`endif
      8'h01: decoded_instruction = I_BRANCH;
      8'h02: decoded_instruction = I_BZERO;
      8'h03: decoded_instruction = I_BNEG;
      8'h05: decoded_instruction = I_BOV;
      8'h06: decoded_instruction = I_BNOV;
      8'h0A: decoded_instruction = I_BNNEG;
      8'h0B: decoded_instruction = I_BNZERO;
      8'hFF: decoded_instruction = I_HALT;
      default: decoded_instruction = I_NOP;
    endcase
  end
  assign alu_fmt  = decoded_instruction inside {I_ADD, I_SUB, I_AND, I_OR, I_MUL};
  assign is_br    = decoded_instruction inside {I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO};
  assign is_mem   = is_br || decoded_instruction == I_LOAD || decoded_instruction == I_STORE;
  assign mem_addr = is_mem ? ir[ADDR_W-1:0] : '0;
  assign rc = decoded_instruction == I_LOAD ? ir[6:5] : decoded_instruction == I_MOVE ? ir[3:2] : alu_fmt ? ir[5:4] : 2'd0;
  assign ra = decoded_instruction == I_STORE ? ir[6:5] : (decoded_instruction == I_MOVE || alu_fmt) ? ir[1:0] : 2'd0;
  assign rb = decoded_instruction == I_MOVE ? ir[1:0] : alu_fmt ? ir[3:2] : 2'd0;
  assign a_op     = r[ra];
  assign b_op     = r[rb];
  assign data_out = a_op;
  assign ram_addr = addr_sel ? mem_addr : pc;
  // full-width ALU with carry/borrow and two's-complement overflow
  always_comb begin
    sum     = {1'b0, a_op} + {1'b0, b_op};
    diff    = {1'b0, a_op} - {1'b0, b_op};
    alu_out = operation == 2'b00 ? sum[M:0] : operation == 2'b01 ? diff[M:0] : operation == 2'b10 ? (a_op & b_op) : (a_op | b_op);
    alu_uov = operation == 2'b00 ? sum[DATA_W] : operation == 2'b01 ? diff[DATA_W] : 1'b0;
    alu_sov = operation == 2'b00 ? (a_op[M] == b_op[M]) && (sum[M] != a_op[M]) :
              operation == 2'b01 ? (a_op[M] != b_op[M]) && (diff[M] != a_op[M]) : 1'b0;
  end
`ifdef KS_DP_MUL_EN
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 2);
  typedef enum logic [1:0] {M_IDLE, M_RUN, M_WB} mul_state_t;
  mul_state_t          state, state_nx;
  logic [2*DATA_W-1:0] acc, mcand;
  logic [DATA_W-1:0]   mplier;
  logic [CNT_W-1:0]    cnt;
  logic                start_ok, done_q;
  assign start_ok = state == M_IDLE && mul_start && decoded_instruction == I_MUL;
  assign prod     = acc + (mplier[0] ? mcand : '0);
  assign wb       = state == M_WB;
  assign mul_busy = state != M_IDLE;
  assign mul_done = done_q;
  // multiplier state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= M_IDLE;
    else state <= state_nx;
  // RUN covers DATA_W-1 bits; the last bit is folded into the WB edge
  always_comb begin
    state_nx = state;
    state_nx = state == M_IDLE ? (start_ok ? M_RUN : M_IDLE) : state == M_RUN ? (cnt == LAST ? M_WB : M_RUN) : M_IDLE;
  end
  // operand capture and shift-add datapath
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      mc     <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= wb;
      if (start_ok) begin
        acc    <= '0;
        mcand  <= {{DATA_W{1'b0}}, a_op};
        mplier <= b_op;
        mc     <= rc;
        cnt    <= '0;
      end else if (state != M_IDLE) begin
        acc    <= prod;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
    end
`else
  logic unused_mul;
  assign unused_mul = mul_start;
  assign wb       = 1'b0;
  assign mc       = 2'd0;
  assign prod     = '0;
  assign mul_busy = 1'b0;
  assign mul_done = 1'b0;
`endif
  // instruction register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ir <= '0;
    else if (ir_enable) ir <= data_in[15:0];
  // program counter: branch target or wrapping increment
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= '0;
    else if (pc_enable) pc <= branch ? mem_addr : pc + 1'b1;
  // register file; multiplier writeback overrides external writes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r <= '{default: '0};
    else if (wb) r[mc] <= prod[M:0];
    else if (write_reg_enable) r[rc] <= c_sel ? data_in : alu_out;
  // flag register; multiplier writeback overrides ALU flag loads
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {zero_op, neg_op, unsigned_overflow, signed_overflow} <= '0;
    else if (wb) {zero_op, neg_op, unsigned_overflow, signed_overflow} <= {prod[M:0] == '0, prod[M], |prod[2*DATA_W-1:DATA_W], 1'b0};
    else if (flags_reg_enable) {zero_op, neg_op, unsigned_overflow, signed_overflow} <= {alu_out == '0, alu_out[M], alu_uov, alu_sov};
endmodule
